boot_spi_master: RTL

//  SPI master (mode 0, MSB first) that reads an image from external SRAM and transmits it in

---
 rtl/boot_spi_pkg.sv | 25 ++
 rtl/spi_byte_tx.sv | 78 +++++++
 rtl/boot_spi_master.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/boot_spi_pkg.sv
// rtl/boot_spi_pkg.sv - shared FSM encoding, sizes and header byte selection for the SPI boot master
package boot_spi_pkg;
  localparam int ADDR_W    = 18;
  localparam int HDR_BYTES = 6;

  typedef enum logic [2:0] {
    ST_IDLE, ST_SETUP, ST_HDR, ST_RD, ST_SHIFT, ST_NEXT, ST_HOLD, ST_DONE
  } state_t;

  // Header order: start address little-endian, then end address little-endian, 3 bytes each.
  function automatic logic [7:0] hdr_byte(input logic [2:0]        idx,
                                          input logic [ADDR_W-1:0] s,
                                          input logic [ADDR_W-1:0] e);
    logic [7:0] b;
    case (idx)
      3'd0:    b = s[7:0];
      3'd1:    b = s[15:8];
      3'd2:    b = {6'b0, s[17:16]};
      3'd3:    b = e[7:0];
      3'd4:    b = e[15:8];
      default: b = {6'b0, e[17:16]};
    endcase
    return b;
  endfunction
endpackage

// File: rtl/spi_byte_tx.sv
// rtl/spi_byte_tx.sv - mode-0 MSB-first byte shifter with CLK_DIV half-period timing
// BOOT_SPI_MISO_CHECK_EN: flag MISO low on each SCK rise.
module spi_byte_tx #(
  parameter int CLK_DIV = 5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [7:0] data,
  input  logic       miso,
  output logic       sck,
  output logic       mosi,
  output logic       byte_done,
  output logic       miso_low
);
  localparam logic [15:0] DIV_M1 = 16'(CLK_DIV - 1);

  logic        active;
  logic [15:0] cnt;
  logic [2:0]  bit_idx;
  logic [7:0]  shreg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active    <= 1'b0;
      cnt       <= '0;
      bit_idx   <= '0;
      shreg     <= '0;
      sck       <= 1'b0;
      mosi      <= 1'b0;
      byte_done <= 1'b0;
    end else begin
      byte_done <= 1'b0;
      if (load) begin
        active  <= 1'b1;
        cnt     <= '0;
        bit_idx <= '0;
        shreg   <= data;
        mosi    <= data[7];
        sck     <= 1'b0;
      end else if (active) begin
        if (cnt == DIV_M1) begin
          cnt <= '0;
          if (!sck) begin
            sck <= 1'b1;
          end else begin
            // Falling edge: next bit goes out while SCK is low.
            sck <= 1'b0;
            if (bit_idx == 3'd7) begin
              active    <= 1'b0;
              byte_done <= 1'b1;
            end else begin
              bit_idx <= bit_idx + 3'd1;
              shreg   <= {shreg[6:0], 1'b0};
              mosi    <= shreg[6];
            end
          end
        end else begin
          cnt <= cnt + 16'd1;
        end
      end
    end
  end

`ifdef BOOT_SPI_MISO_CHECK_EN
  logic rise;
  assign rise = active && !load && !sck && (cnt == DIV_M1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) miso_low <= 1'b0;
    else        miso_low <= rise && !miso;
  end
`else
  logic unused_miso;
  assign unused_miso = miso;
  assign miso_low    = 1'b0;
`endif
endmodule

// File: rtl/boot_spi_master.sv
// rtl/boot_spi_master.sv - streams an SRAM address range out over SPI in boot-loader framing
// BOOT_SPI_MISO_CHECK_EN: enables the sticky miso_err flag.
module boot_spi_master
  import boot_spi_pkg::*;
#(
  parameter int CLK_DIV   = 5,
  parameter int RD_CYCLES = 2,
  parameter int SSEL_SU   = 4,
  parameter int GAP       = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [ADDR_W-1:0] end_addr,
  output logic              busy,
  output logic              done,
  output logic              miso_err,
  output logic              SCK,
  output logic              SSEL,
  output logic              MOSI,
  input  logic              MISO,
  output logic              ram_RAMCS_b,
  output logic              ram_RAMOE_b,
  output logic [ADDR_W-1:0] ram_RAMA,
  input  logic [7:0]        ram_RAMDout
);
  localparam logic [15:0] SU_M1 = 16'(SSEL_SU - 1);
  localparam logic [15:0] RD_M1 = 16'(RD_CYCLES - 1);
  localparam logic [15:0] GAP_N = 16'(GAP);
  localparam logic [2:0]  HDR_LAST = 3'(HDR_BYTES - 1);

  state_t            state;
  logic [ADDR_W-1:0] s_addr, e_addr, cur;
  logic [15:0]       cnt, gap_cnt;
  logic [2:0]        hdr_idx;
  logic              sent, tx_load, byte_done, miso_low;
  logic [7:0]        tx_data;

  spi_byte_tx #(.CLK_DIV(CLK_DIV)) u_tx (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (tx_load),
    .data      (tx_data),
    .miso      (MISO),
    .sck       (SCK),
    .mosi      (MOSI),
    .byte_done (byte_done),
    .miso_low  (miso_low)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      s_addr      <= '0;
      e_addr      <= '0;
      cur         <= '0;
      cnt         <= '0;
      gap_cnt     <= '0;
      hdr_idx     <= '0;
      sent        <= 1'b0;
      tx_load     <= 1'b0;
      tx_data     <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      SSEL        <= 1'b1;
      ram_RAMCS_b <= 1'b1;
      ram_RAMOE_b <= 1'b1;
      ram_RAMA    <= '0;
    end else begin
      tx_load <= 1'b0;
      done    <= 1'b0;
      // gap_cnt runs down after every byte; the SRAM read proceeds in parallel.
      if (gap_cnt != 16'd0) gap_cnt <= gap_cnt - 16'd1;
      case (state)
        ST_IDLE: begin
          if (start) begin
            s_addr <= start_addr;
            e_addr <= end_addr;
            cur    <= start_addr;
            busy   <= 1'b1;
            SSEL   <= 1'b0;
            cnt    <= '0;
            state  <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          if (cnt == SU_M1) begin
            cnt     <= '0;
            hdr_idx <= '0;
            sent    <= 1'b0;
            gap_cnt <= '0;
            state   <= ST_HDR;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        ST_HDR: begin
          if (!sent) begin
            if (gap_cnt == 16'd0) begin
              tx_load <= 1'b1;
              tx_data <= hdr_byte(hdr_idx, s_addr, e_addr);
              sent    <= 1'b1;
            end
          end else if (byte_done) begin
            sent    <= 1'b0;
            gap_cnt <= GAP_N;
            if (hdr_idx == HDR_LAST) begin
              ram_RAMCS_b <= 1'b0;
              ram_RAMOE_b <= 1'b0;
              ram_RAMA    <= cur;
              cnt         <= '0;
              state       <= ST_RD;
            end else begin
              hdr_idx <= hdr_idx + 3'd1;
            end
          end
        end
        ST_RD: begin
          if (cnt == RD_M1) begin
            tx_data     <= ram_RAMDout;
            ram_RAMCS_b <= 1'b1;
            ram_RAMOE_b <= 1'b1;
            sent        <= 1'b0;
            state       <= ST_SHIFT;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        ST_SHIFT: begin
          if (!sent) begin
            if (gap_cnt == 16'd0) begin
              tx_load <= 1'b1;
              sent    <= 1'b1;
            end
          end else if (byte_done) begin
            sent    <= 1'b0;
            gap_cnt <= GAP_N;
            state   <= ST_NEXT;
          end
        end
        ST_NEXT: begin
          if (cur == e_addr) begin
            cnt   <= '0;
            state <= ST_HOLD;
          end else begin
            cur         <= cur + 1'b1;
            ram_RAMCS_b <= 1'b0;
            ram_RAMOE_b <= 1'b0;
            ram_RAMA    <= cur + 1'b1;
            cnt         <= '0;
            state       <= ST_RD;
          end
        end
        ST_HOLD: begin
          if (cnt == SU_M1) begin
            SSEL  <= 1'b1;
            state <= ST_DONE;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        ST_DONE: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef BOOT_SPI_MISO_CHECK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                        miso_err <= 1'b0;
    else if (state == ST_IDLE && start) miso_err <= 1'b0;
    else if (miso_low)                 miso_err <= 1'b1;
  end
`else
  logic unused_miso_low;
  assign unused_miso_low = miso_low;
  assign miso_err        = 1'b0;
`endif
endmodule
